calc_unit_param: RTL and testbench
==================================

Name: calc_unit_param

Overview:
- Parametrised next-generation calculator: operand/function capture, control FSM and datapath in one block.
- Operand width generalised to W.
- Adds iterative shift-add multiply and restoring divide, a busy flag, and a sticky error until the next command.
- Sits under the lab top level, fed by switches/buttons, driving the display out_h/out_l.

Parameters:
- W, 4, operand width in bits (2..16).
- CW, $clog2(W+1), iteration-counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- go  input  1  start command; sampled only in IDLE.
- x  input  W  operand A.
- y  input  W  operand B.
- F  input  3  function select.
- busy  output  1  high from accept until done.
- done  output  1  one-cycle completion pulse.
- error  output  1  sticky error flag.
- out_h  output  W  high result word.
- out_l  output  W  low result word.
- cs  output  3  current FSM state, for debug/LEDs.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all of busy, done, error, out_h, out_l and the internal regs go to 0; counter 0. Reset mid-operation aborts with no done.
- Accept: in IDLE, at a rising edge with go=1:
  - x, y, F are latched; error clears; busy goes to 1.
  - Next state: EXEC (F 000–100), MULT (101), DIV (110), or ERR (111, or 110 with y==0).
- go while busy is ignored. Inputs x, y, F may change after accept without effect.
- F encoding:
  - 000 add: out_l = sum mod 2^W; out_h = {(W-1)'b0, carry}.
  - 001 sub: out_l = x-y mod 2^W; out_h = all ones if x<y (unsigned), else 0.
  - 010 AND, 011 OR, 100 XOR: result on out_l; out_h = 0.
  - 101 mult: {out_h, out_l} = x*y (full 2W bits).
  - 110 div: out_l = quotient, out_h = remainder.
  - 111: illegal.
- FSM states: IDLE, EXEC, MULT, DIV, DONE, ERR.
  - EXEC: 1 cycle, result registered, then DONE.
  - MULT: exactly W cycles of shift-add (counter W-1 down to 0), then DONE.
  - DIV: exactly W cycles of restoring divide, then DONE.
  - DONE: done=1 for one cycle; outputs updated on entry to DONE; then IDLE with busy=0.
  - ERR: one cycle; error=1 (sticky), done=1, out_h/out_l = 0; then IDLE.
- Latency (accept edge = edge 0): done is high in the cycle following edge 2 for ALU ops, edge W+2 for mult/div, and edge 2 for errors.
- Outputs hold their value from DONE until the next DONE or ERR.
- Divide boundaries: x<y gives q=0, r=x; x=0 gives q=0, r=0; y=1 gives q=x, r=0.
- All arithmetic is unsigned unless the optional feature below is enabled.

Optional Feature:
- Macro: CALC_SIGNED_EN.
- Defined:
  - F=101 and F=110 treat x, y as two's complement.
  - Operands are converted to magnitudes, the same W-cycle iteration runs, and results are negated in DONE entry per sign rules.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Divide of most-negative by -1 goes to ERR.
  - sub out_h uses a signed compare.
  - Latency unchanged.
- Undefined: all ops unsigned; no sign logic synthesised.

Decomposition:
- Package calc_pkg: F opcode localparams (OP_ADD..OP_ILL) and state encoding localparams (S_IDLE..S_ERR, 3 bits).
- One sub-module, calc_iter_muldiv:
  - Shared W-cycle shift engine (start, mode, a, b → hi, lo, fin).
  - Instantiated once and driven by the FSM.
- ALU ops stay inline.

Test Plan:
- Reset mid-MULT: go with x=9, y=7, F=101 (W=4); assert rst low after 2 cycles → all outputs 0, cs=IDLE, no done pulse.
- Add carry: x=15, y=1, F=000 → done at edge 2; out_h=1, out_l=0, error=0.
- Mult: x=13, y=11, F=101 → done at edge 6; {out_h,out_l}=143 (out_h=8, out_l=15).
- Div: x=14, y=3, F=110 → done at edge 6; out_l=4, out_h=2. Then x=5, y=0, F=110 → error=1, done at edge 2, outputs 0; next go with F=000 clears error.
- Busy/ignore and illegal op:
  - go held high during a mult → exactly one done, no restart.
  - F=111 → ERR path.
- CALC_SIGNED_EN build: x=-7, y=2, F=110 → out_l=-3 (4'hD), out_h=-1 (4'hF). x=-8, y=-1, F=110 → error=1.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: opcode and FSM state encodings shared by the calculator blocks.
package calc_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_DIV = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EXEC = 3'd1;
  localparam logic [2:0] S_MULT = 3'd2;
  localparam logic [2:0] S_DIV  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;
endpackage

// File: rtl/calc_iter_muldiv.sv
// calc_iter_muldiv: shared W-cycle engine, shift-add multiply (mode=0) or restoring divide (mode=1).
// Operands load on start; fin pulses one cycle after the last iteration.
module calc_iter_muldiv #(parameter int W = 4) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         fin
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0] m, nh, nl;
  logic [CW-1:0] cnt;
  logic md, run;
  logic [W:0] s, t, d;
  // Remainder stays below the divisor, so d[W] is a clean borrow flag.
  always_comb begin
    s  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    t  = {hi, lo[W-1]};
    d  = t - {1'b0, m};
    nh = md ? (d[W] ? t[W-1:0] : d[W-1:0]) : s[W:1];
    nl = md ? {lo[W-2:0], ~d[W]} : {s[0], lo[W-1:1]};
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hi <= '0; lo <= '0; m <= '0; md <= 1'b0; run <= 1'b0; cnt <= '0; fin <= 1'b0;
    end else begin
      fin <= 1'b0;
      if (start) begin
        hi <= '0; lo <= mode ? a : b; m <= mode ? b : a; md <= mode; run <= 1'b1; cnt <= CW'(W - 1);
      end else if (run) begin
        hi <= nh; lo <= nl; cnt <= cnt - 1'b1;
        if (cnt == '0) begin run <= 1'b0; fin <= 1'b1; end
      end
    end
endmodule

// File: rtl/calc_unit_param.sv
// calc_unit_param: W-bit calculator with ALU ops, iterative mult/div, busy flag and sticky error.
// Define CALC_SIGNED_EN for two's-complement mult/div and signed subtract compare.
module calc_unit_param
  import calc_pkg::*;
#(parameter int W = 4) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [2:0]   F,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [W-1:0] out_h,
  output logic [W-1:0] out_l,
  output logic [2:0]   cs
);
  logic [W-1:0] xr, yr, hi, lo, ma, mb, alu_h, alu_l, qm, rm;
  logic [2*W-1:0] pm;
  logic [2:0] fr;
  logic [W:0] sum;
  logic bad, lt, fin, st;
`ifdef CALC_SIGNED_EN
  logic sq, sr;
  // Engine works on magnitudes; signs are reapplied when results are captured.
  assign ma  = x[W-1] ? -x : x;
  assign mb  = y[W-1] ? -y : y;
  assign bad = y == '0 || (x == {1'b1, {(W-1){1'b0}}} && y == '1);
  assign lt  = $signed(xr) < $signed(yr);
  assign pm  = sq ? -{hi, lo} : {hi, lo};
  assign qm  = sq ? -lo : lo;
  assign rm  = sr ? -hi : hi;
`else
  assign ma  = x;
  assign mb  = y;
  assign bad = y == '0;
  assign lt  = xr < yr;
  assign pm  = {hi, lo};
  assign qm  = lo;
  assign rm  = hi;
`endif
  assign sum = {1'b0, xr} + {1'b0, yr};
  always_comb begin
    alu_l = fr == OP_ADD ? sum[W-1:0] : fr == OP_SUB ? xr - yr : fr == OP_AND ? xr & yr :
            fr == OP_OR ? xr | yr : xr ^ yr;
    alu_h = fr == OP_ADD ? W'(sum[W]) : fr == OP_SUB ? {W{lt}} : '0;
  end
  assign st = cs == S_IDLE && go && (F == OP_MUL || (F == OP_DIV && !bad));
  calc_iter_muldiv #(.W(W)) u_iter (
    .clk(clk), .rst(rst), .start(st), .mode(F == OP_DIV), .a(ma), .b(mb),
    .hi(hi), .lo(lo), .fin(fin)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cs <= S_IDLE; busy <= 1'b0; done <= 1'b0; error <= 1'b0;
      out_h <= '0; out_l <= '0; xr <= '0; yr <= '0; fr <= '0;
`ifdef CALC_SIGNED_EN
      sq <= 1'b0; sr <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (cs)
        S_IDLE: if (go) begin
          xr <= x; yr <= y; fr <= F; error <= 1'b0; busy <= 1'b1;
`ifdef CALC_SIGNED_EN
          sq <= x[W-1] ^ y[W-1]; sr <= x[W-1];
`endif
          cs <= (F == OP_ILL || (F == OP_DIV && bad)) ? S_ERR :
                F == OP_MUL ? S_MULT : F == OP_DIV ? S_DIV : S_EXEC;
        end
        S_EXEC: begin out_h <= alu_h; out_l <= alu_l; cs <= S_DONE; end
        S_MULT: if (fin) begin {out_h, out_l} <= pm; cs <= S_DONE; end
        S_DIV:  if (fin) begin out_h <= rm; out_l <= qm; cs <= S_DONE; end
        S_DONE: begin done <= 1'b1; busy <= 1'b0; cs <= S_IDLE; end
        S_ERR:  begin error <= 1'b1; out_h <= '0; out_l <= '0; cs <= S_DONE; end
        default: cs <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_calc_unit_param.sv
// tb_calc_unit_param: scoreboard bench, directed vectors with hand-computed results for W=4.
module tb_calc_unit_param;
  logic clk = 1'b0, rst = 1'b0, go = 1'b0;
  logic [3:0] x = '0, y = '0, out_h, out_l;
  logic [2:0] f = '0, cs;
  logic busy, done, error;
  int n = 0, checks = 0, errors = 0;
  typedef struct { string nm; logic [3:0] h; logic [3:0] l; logic e; int due; } exp_t;
  exp_t sb[$];

  calc_unit_param #(.W(4)) dut (
    .clk(clk), .rst(rst), .go(go), .x(x), .y(y), .F(f),
    .busy(busy), .done(done), .error(error), .out_h(out_h), .out_l(out_l), .cs(cs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) n <= n + 1;

  always @(negedge clk) if (rst && done) begin
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_done: got h=%h l=%h e=%b at edge %0d, required no done", out_h, out_l, error, n);
    end else begin
      exp_t e;
      e = sb.pop_front();
      if (out_h !== e.h || out_l !== e.l || error !== e.e || busy !== 1'b0 || n != e.due) begin
        errors++;
        $display("FAIL %s: got h=%h l=%h e=%b busy=%b edge=%0d, required h=%h l=%h e=%b busy=0 edge=%0d",
                 e.nm, out_h, out_l, error, busy, n, e.h, e.l, e.e, e.due);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, got, req);
    end
  endtask

  task automatic issue(input string nm, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] h, input logic [3:0] l, input logic e, input int lat);
    exp_t t;
    @(negedge clk);
    x = a; y = b; f = op; go = 1'b1;
    t.nm = nm; t.h = h; t.l = l; t.e = e; t.due = n + 1 + lat;
    sb.push_back(t);
    @(negedge clk);
    go = 1'b0; x = ~a; y = ~b; f = 3'd4;
    chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
    chk({nm, "_errclr"}, {31'd0, error}, 32'd0);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done, required done within 40 cycles", nm);
      sb.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_state", {busy, done, error, out_h, out_l, cs}, '0);
    // Abort a multiply mid-flight: no expectation is queued, so any done is flagged.
    x = 4'd9; y = 4'd7; f = 3'd5; go = 1'b1;
    @(negedge clk); go = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; #1;
    chk("reset_mid_mult", {busy, done, error, out_h, out_l, cs}, '0);
    @(negedge clk); rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("reset_idle", {28'd0, busy, cs}, '0);

    issue("add_carry", 3'd0, 4'd15, 4'd1, 4'h1, 4'h0, 1'b0, 2);
    issue("add_plain", 3'd0, 4'd3, 4'd4, 4'h0, 4'h7, 1'b0, 2);
    issue("sub_pos", 3'd1, 4'd5, 4'd3, 4'h0, 4'h2, 1'b0, 2);
    issue("sub_neg", 3'd1, 4'd3, 4'd5, 4'hF, 4'hE, 1'b0, 2);
    issue("and", 3'd2, 4'hC, 4'hA, 4'h0, 4'h8, 1'b0, 2);
    issue("or", 3'd3, 4'hC, 4'hA, 4'h0, 4'hE, 1'b0, 2);
    issue("xor", 3'd4, 4'hC, 4'hA, 4'h0, 4'h6, 1'b0, 2);
`ifdef CALC_SIGNED_EN
    issue("mul_13_11", 3'd5, 4'd13, 4'd11, 4'h0, 4'hF, 1'b0, 6);
    issue("mul_15_15", 3'd5, 4'd15, 4'd15, 4'h0, 4'h1, 1'b0, 6);
    issue("mul_7_m2", 3'd5, 4'd7, 4'hE, 4'hF, 4'h2, 1'b0, 6);
    issue("div_14_3", 3'd6, 4'd14, 4'd3, 4'hE, 4'h0, 1'b0, 6);
    issue("div_m7_2", 3'd6, 4'h9, 4'd2, 4'hF, 4'hD, 1'b0, 6);
    issue("div_m8_m1", 3'd6, 4'h8, 4'hF, 4'h0, 4'h0, 1'b1, 2);
`else
    issue("mul_13_11", 3'd5, 4'd13, 4'd11, 4'h8, 4'hF, 1'b0, 6);
    issue("mul_15_15", 3'd5, 4'd15, 4'd15, 4'hE, 4'h1, 1'b0, 6);
    issue("div_14_3", 3'd6, 4'd14, 4'd3, 4'h2, 4'h4, 1'b0, 6);
    issue("div_15_2", 3'd6, 4'd15, 4'd2, 4'h1, 4'h7, 1'b0, 6);
`endif
    issue("div_x_lt_y", 3'd6, 4'd2, 4'd5, 4'h2, 4'h0, 1'b0, 6);
    issue("div_x_zero", 3'd6, 4'd0, 4'd3, 4'h0, 4'h0, 1'b0, 6);
    issue("div_y_one", 3'd6, 4'd7, 4'd1, 4'h0, 4'h7, 1'b0, 6);
    issue("div_by_zero", 3'd6, 4'd5, 4'd0, 4'h0, 4'h0, 1'b1, 2);
    repeat (3) @(negedge clk);
    chk("error_sticky", {31'd0, error}, 32'd1);
    issue("add_after_err", 3'd0, 4'd1, 4'd1, 4'h0, 4'h2, 1'b0, 2);
    issue("illegal_op", 3'd7, 4'd3, 4'd3, 4'h0, 4'h0, 1'b1, 2);
    chk("outputs_hold", {23'd0, error, out_h, out_l}, {23'd0, 1'b1, 8'h00});

    // go held during a multiply must not restart it: one done only.
    begin
      exp_t t;
      @(negedge clk);
      x = 4'd3; y = 4'd5; f = 3'd5; go = 1'b1;
      t.nm = "mul_go_held"; t.h = 4'h0; t.l = 4'hF; t.e = 1'b0; t.due = n + 7;
      sb.push_back(t);
      repeat (4) @(negedge clk);
      chk("busy_while_go", {31'd0, busy}, 32'd1);
      go = 1'b0;
      repeat (12) @(negedge clk);
      chk("mul_go_held_drained", sb.size(), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1);
  end
endmodule
